fetch_pc_unit: RTL and testbench

- Fetch-stage PC generator and instruction buffer, directly upstream of decode.
- Holds the architectural fetch PC and issues single-outstanding requests to instruction memory.
- Buffers returned instructions in a 2-entry FIFO with their PC and PC+4 for decode.
- Consumes the decode-stage redirect target, either a jump/branch target or a recovery PC+4, and squashes wrong-path fetches.

---
 rtl/fetch_pc_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//
// Fetch-stage PC generator and two-entry instruction buffer feeding decode.
// Keeps the architectural fetch PC and issues one instruction-memory request
// at a time. Returned words are queued with their PC and PC+4. A decode
// redirect moves the fetch PC, flushes the buffer and drops any response
// that belongs to the wrong path.
//
// Optional feature: define FETCH_BTB_EN to add a direct-mapped branch target
// buffer. It predicts the next fetch PC at grant time and marks the fetched
// instruction as predicted-taken. Without the macro the next PC is always
// PC+4, oPredTakenF is 0 and the BTB update inputs are ignored.
//
// Ports:
//   iClk, iRstN        clock, asynchronous active-low reset
//   iStallF            hold the buffer head (no dequeue)
//   iRedirectD         decode redirect valid, target on iPCTargetD
//   oImemReq/oImemAddr instruction memory request and word address
//   iImemGnt           request accepted this cycle
//   iImemRvalid/Rdata  memory response (one per granted request)
//   oValidF, oInstrF, oPCF, oPCPlus4F, oPredTakenF   buffer head to decode
//   iReadyD            decode takes the head this cycle
//   oMisalignF         one-cycle pulse: redirect target was not word aligned
//   iBtbUpdate, iBtbPC, iBtbTarget   resolved taken branch for the BTB
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iStallF,
    input  logic        iRedirectD,
    input  logic [31:0] iPCTargetD,
    output logic        oImemReq,
    output logic [31:0] oImemAddr,
    input  logic        iImemGnt,
    input  logic        iImemRvalid,
    input  logic [31:0] iImemRdata,
    output logic        oValidF,
    output logic [31:0] oInstrF,
    output logic [31:0] oPCF,
    output logic [31:0] oPCPlus4F,
    output logic        oPredTakenF,
    input  logic        iReadyD,
    output logic        oMisalignF,
    input  logic        iBtbUpdate,
    input  logic [31:0] iBtbPC,
    input  logic [31:0] iBtbTarget
);

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pcF;
    logic [31:0] r_reqPC;
    logic        r_reqPred;
    logic        r_discard;
    logic        w_discardNext;
    logic        r_misalign;

    logic [31:0] r_fifoInstr   [2];
    logic [31:0] r_fifoPC      [2];
    logic [31:0] r_fifoPCPlus4 [2];
    logic        r_fifoPred    [2];
    logic        r_head;
    logic [1:0]  r_count;

    logic        w_notFull;
    logic        w_grantAcc;
    logic        w_enq;
    logic        w_deq;
    logic        w_tail;
    logic [31:0] w_nextPC;
    logic        w_predHit;

    assign w_notFull = (r_count != 2'd2);
    // Tail slot: with count 0 it is the head slot, with count 1 the other one.
    assign w_tail    = r_head ^ r_count[0];
    // A redirect wins over decode acceptance, so nothing is dequeued then.
    assign w_deq     = (r_count != 2'd0) & iReadyD & ~iStallF & ~iRedirectD;

`ifdef FETCH_BTB_EN
    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic            r_btbValid  [BTB_ENTRIES];
    logic [TAGW-1:0] r_btbTag    [BTB_ENTRIES];
    logic [29:0]     r_btbTarget [BTB_ENTRIES];
    logic [IDXW-1:0] w_lookIdx;
    logic [IDXW-1:0] w_updIdx;
    logic            w_unusedBtb;

    assign w_lookIdx   = r_pcF[IDXW+1:2];
    assign w_updIdx    = iBtbPC[IDXW+1:2];
    assign w_predHit   = r_btbValid[w_lookIdx] &&
                         (r_btbTag[w_lookIdx] == r_pcF[31:IDXW+2]);
    assign w_nextPC    = w_predHit ? {r_btbTarget[w_lookIdx], 2'b00}
                                   : r_pcF + 32'd4;
    assign w_unusedBtb = ^{iBtbPC[1:0], iBtbTarget[1:0]};

    // BTB valid bits: the only BTB state that needs a reset. The write lands
    // at the clock edge, so a lookup in the same cycle sees the old entry.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btbValid[i] <= 1'b0;
            end
        end else if (iBtbUpdate) begin
            r_btbValid[w_updIdx] <= 1'b1;
        end
    end

    // BTB tag and target payload, qualified by the valid bits above.
    always_ff @(posedge iClk) begin
        if (iBtbUpdate) begin
            r_btbTag[w_updIdx]    <= iBtbPC[31:IDXW+2];
            r_btbTarget[w_updIdx] <= iBtbTarget[31:2];
        end
    end
`else
    logic w_unusedBtb;

    assign w_predHit   = 1'b0;
    assign w_nextPC    = r_pcF + 32'd4;
    assign w_unusedBtb = ^{iBtbUpdate, iBtbPC, iBtbTarget, BTB_ENTRIES[0]};
`endif

    // Request/response FSM state register.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state   <= ST_ISSUE;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_discard <= w_discardNext;
        end
    end

    // Next state. A redirect during an outstanding request, or coincident
    // with a grant, marks the pending response as stale. A response that
    // arrives in the same cycle as a redirect is simply dropped, so no
    // discard flag is needed for it.
    always_comb begin
        w_stateNext   = r_state;
        w_discardNext = r_discard;
        w_grantAcc    = 1'b0;
        w_enq         = 1'b0;
        unique case (r_state)
            ST_ISSUE: begin
                if (iImemGnt && w_notFull) begin
                    w_grantAcc    = 1'b1;
                    w_stateNext   = ST_WAIT;
                    w_discardNext = iRedirectD;
                end
            end
            ST_WAIT: begin
                if (iImemRvalid) begin
                    w_stateNext   = ST_ISSUE;
                    w_discardNext = 1'b0;
                    w_enq         = ~r_discard & ~iRedirectD;
                end else if (iRedirectD) begin
                    w_discardNext = 1'b1;
                end
            end
        endcase
    end

    // Fetch PC and the PC/prediction of the request in flight.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_pcF      <= RESET_PC;
            r_reqPC    <= 32'h0;
            r_reqPred  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= iRedirectD & (|iPCTargetD[1:0]);
            if (iRedirectD) begin
                r_pcF <= {iPCTargetD[31:2], 2'b00};
            end else if (w_grantAcc) begin
                r_pcF <= w_nextPC;
            end
            if (w_grantAcc) begin
                r_reqPC   <= r_pcF;
                r_reqPred <= w_predHit;
            end
        end
    end

    // Two-entry instruction buffer. A request is only issued while it is not
    // full and only one request is outstanding, so an accepted response
    // always finds a free slot.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifoInstr[i]   <= 32'h0;
                r_fifoPC[i]      <= 32'h0;
                r_fifoPCPlus4[i] <= 32'h0;
                r_fifoPred[i]    <= 1'b0;
            end
        end else if (iRedirectD) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) begin
                r_fifoInstr[w_tail]   <= iImemRdata;
                r_fifoPC[w_tail]      <= r_reqPC;
                r_fifoPCPlus4[w_tail] <= r_reqPC + 32'd4;
                r_fifoPred[w_tail]    <= r_reqPred;
            end
            if (w_deq) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    // Request is held low during reset so every output is quiet then.
    assign oImemReq    = iRstN & (r_state == ST_ISSUE) & w_notFull & ~iRedirectD;
    assign oImemAddr   = r_pcF;
    assign oValidF     = (r_count != 2'd0);
    assign oInstrF     = r_fifoInstr[r_head];
    assign oPCF        = r_fifoPC[r_head];
    assign oPCPlus4F   = r_fifoPCPlus4[r_head];
    assign oPredTakenF = r_fifoPred[r_head];
    assign oMisalignF  = r_misalign;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Directed bench for fetch_pc_unit. A small instruction memory grants every
// request immediately and answers one cycle later; memHold delays the answer.
// Memory words are a fixed function of the address so the expected head
// instruction follows from the expected PC. Build with FETCH_BTB_EN defined
// to check the predicted path instead of the sequential one.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

`ifdef FETCH_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        iClk;
    logic        iRstN;
    logic        iStallF;
    logic        iRedirectD;
    logic [31:0] iPCTargetD;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemGnt;
    logic        iImemRvalid;
    logic [31:0] iImemRdata;
    logic        oValidF;
    logic [31:0] oInstrF;
    logic [31:0] oPCF;
    logic [31:0] oPCPlus4F;
    logic        oPredTakenF;
    logic        iReadyD;
    logic        oMisalignF;
    logic        iBtbUpdate;
    logic [31:0] iBtbPC;
    logic [31:0] iBtbTarget;

    logic        memHold;
    logic        memPend;
    logic [31:0] memAddr;

    int vectors;
    int miscompares;

    fetch_pc_unit #(
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16)
    ) dut (
        .iClk        (iClk),
        .iRstN       (iRstN),
        .iStallF     (iStallF),
        .iRedirectD  (iRedirectD),
        .iPCTargetD  (iPCTargetD),
        .oImemReq    (oImemReq),
        .oImemAddr   (oImemAddr),
        .iImemGnt    (iImemGnt),
        .iImemRvalid (iImemRvalid),
        .iImemRdata  (iImemRdata),
        .oValidF     (oValidF),
        .oInstrF     (oInstrF),
        .oPCF        (oPCF),
        .oPCPlus4F   (oPCPlus4F),
        .oPredTakenF (oPredTakenF),
        .iReadyD     (iReadyD),
        .oMisalignF  (oMisalignF),
        .iBtbUpdate  (iBtbUpdate),
        .iBtbPC      (iBtbPC),
        .iBtbTarget  (iBtbTarget)
    );

    // Free-running clock, period 10.
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    // Instruction memory: grant on request, answer after at least one cycle.
    assign iImemGnt    = oImemReq;
    assign iImemRvalid = memPend & ~memHold;
    assign iImemRdata  = memWord(memAddr);

    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            memPend <= 1'b0;
            memAddr <= 32'h0;
        end else if (oImemReq && iImemGnt) begin
            memPend <= 1'b1;
            memAddr <= oImemAddr;
        end else if (iImemRvalid) begin
            memPend <= 1'b0;
        end
    end

    // One cycle: drive inputs just after the falling edge, settle, return.
    task automatic applyStimulus(input logic ready, input logic stall,
                                 input logic redirect, input logic [31:0] target,
                                 input logic hold);
        @(negedge iClk);
        iRstN      = 1'b1;
        iReadyD    = ready;
        iStallF    = stall;
        iRedirectD = redirect;
        iPCTargetD = target;
        memHold    = hold;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Put the DUT in reset with idle inputs; the next applyStimulus releases it.
    task automatic doReset();
        @(negedge iClk);
        iRstN      = 1'b0;
        iReadyD    = 1'b0;
        iStallF    = 1'b0;
        iRedirectD = 1'b0;
        iPCTargetD = 32'h0;
        memHold    = 1'b0;
        iBtbUpdate = 1'b0;
        iBtbPC     = 32'h0;
        iBtbTarget = 32'h0;
        @(negedge iClk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset values.
        doReset();
        checkOutput("rst_addr",   oImemAddr,   32'h0);
        checkOutput("rst_req",    oImemReq,    1'b0);
        checkOutput("rst_valid",  oValidF,     1'b0);
        checkOutput("rst_instr",  oInstrF,     32'h0);
        checkOutput("rst_pc",     oPCF,        32'h0);
        checkOutput("rst_pc4",    oPCPlus4F,   32'h0);
        checkOutput("rst_pred",   oPredTakenF, 1'b0);
        checkOutput("rst_misal",  oMisalignF,  1'b0);

        // Sequential fetch with decode always ready.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("seq_req0",   oImemReq,  1'b1);
        checkOutput("seq_addr0",  oImemAddr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("seq_rvalid_novalid", oValidF, 1'b0);
        checkOutput("seq_wait_req",       oImemReq, 1'b0);
        checkOutput("seq_addr4",          oImemAddr, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("seq_valid0", oValidF,   1'b1);
        checkOutput("seq_pc0",    oPCF,      32'h0);
        checkOutput("seq_pc4_0",  oPCPlus4F, 32'h4);
        checkOutput("seq_instr0", oInstrF,   memWord(32'h0));
        checkOutput("seq_req4",   oImemReq,  1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("seq_empty",  oValidF,   1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("seq_pc1",    oPCF,      32'h4);
        checkOutput("seq_pc4_1",  oPCPlus4F, 32'h8);
        checkOutput("seq_addr8",  oImemAddr, 32'h8);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("seq_pc2",    oPCF,      32'h8);
        checkOutput("seq_pc4_2",  oPCPlus4F, 32'hC);
        checkOutput("seq_instr2", oInstrF,   memWord(32'h8));
        checkOutput("seq_addr12", oImemAddr, 32'hC);

        // Decode not ready: buffer fills with PC 0 and 4, then requests stop.
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        checkOutput("full_valid", oValidF,   1'b1);
        checkOutput("full_pc",    oPCF,      32'h0);
        checkOutput("full_req",   oImemReq,  1'b0);
        checkOutput("full_addr",  oImemAddr, 32'h8);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("drain_pc0",  oPCF,      32'h0);
        checkOutput("drain_req0", oImemReq,  1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("drain_pc1",  oPCF,      32'h4);
        checkOutput("drain_req1", oImemReq,  1'b1);
        checkOutput("drain_addr", oImemAddr, 32'h8);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("drain_empty", oValidF,  1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("drain_pc2",  oPCF,      32'h8);

        // Redirect to 0x100 while the PC 8 response is still outstanding.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rd_pc4",     oPCF,      32'h4);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
        checkOutput("rd_req_blk", oImemReq,  1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_flush",   oValidF,   1'b0);
        checkOutput("rd_addr",    oImemAddr, 32'h100);
        checkOutput("rd_waitreq", oImemReq,  1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_dropped", oValidF,   1'b0);
        checkOutput("rd_req",     oImemReq,  1'b1);
        checkOutput("rd_addr2",   oImemAddr, 32'h100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_valid",   oValidF,   1'b1);
        checkOutput("rd_pc",      oPCF,      32'h100);
        checkOutput("rd_pc4",     oPCPlus4F, 32'h104);
        checkOutput("rd_instr",   oInstrF,   memWord(32'h100));

        // Misaligned redirect target 0x202 resumes at 0x200.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h202, 1'b0);
        checkOutput("mis_req",    oImemReq,   1'b0);
        checkOutput("mis_before", oMisalignF, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("mis_pulse",  oMisalignF, 1'b1);
        checkOutput("mis_valid",  oValidF,    1'b0);
        checkOutput("mis_addr",   oImemAddr,  32'h200);
        checkOutput("mis_req1",   oImemReq,   1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("mis_end",    oMisalignF, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("mis_pc",     oPCF,       32'h200);
        checkOutput("mis_pc4",    oPCPlus4F,  32'h204);

        // Stall holds head PC 4; a redirect during the stall still flushes.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("stl_pc_a",   oPCF,     32'h4);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("stl_pc_b",   oPCF,     32'h4);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
        checkOutput("stl_pc_c",   oPCF,     32'h4);
        checkOutput("stl_full",   oImemReq, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("stl_flush",  oValidF,  1'b0);
        checkOutput("stl_addr",   oImemAddr, 32'h300);
        checkOutput("stl_req",    oImemReq, 1'b1);

        // BTB entry PC 0x10 -> 0x40, then fetch from 0x10.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
        iBtbUpdate = 1'b1;
        iBtbPC     = 32'h10;
        iBtbTarget = 32'h40;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        iBtbUpdate = 1'b0;
        checkOutput("btb_addr10", oImemAddr, 32'h10);
        checkOutput("btb_req",    oImemReq,  1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("btb_next",   oImemAddr, BTB_ON ? 32'h40 : 32'h14);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("btb_pc",     oPCF,        32'h10);
        checkOutput("btb_pc4",    oPCPlus4F,   32'h14);
        checkOutput("btb_pred",   oPredTakenF, BTB_ON ? 1'b1 : 1'b0);

        // PC arithmetic wraps at the top of the address space.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap_addr",  oImemAddr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap_next",  oImemAddr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap_pc",    oPCF,        32'hFFFF_FFFC);
        checkOutput("wrap_pc4",   oPCPlus4F,   32'h0);
        checkOutput("wrap_pred",  oPredTakenF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
